pc_fetch_unit: RTL

Program-counter and instruction-fetch stage sitting directly downstream of the next-PC 2:1 multiplexer. Holds the 8-bit PC, drives `pc_plus1` into the mux's `input0`, and samples the mux's `outputMux` as `next_pc` when the current instruction is retired. Runs a request/acknowledge handshake to instruction memory and a valid/ready handshake to decode.

---
 rtl/pc_fetch_unit.sv | 88 ++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: req/ack fetch from instruction
// memory, valid/ready hand-off to decode. Define PC_TRACE_EN for an accept trace.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [ADDR_W-1:0]  next_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus1,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic fetch_done;
    logic accept;

    assign fetch_done = (state == REQ)  && imem_ack;
    assign accept     = (state == HOLD) && instr_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state_nxt gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run)        state_nxt = REQ;
            REQ:     if (imem_ack)   state_nxt = HOLD;
            HOLD:    if (instr_ready) state_nxt = run ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fetched word and its address are captured once per fetch and then held
    // for decode; the PC only moves on the decode accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            if (fetch_done) begin
                instr    <= imem_data;
                instr_pc <= pc;
            end
            if (accept) pc <= next_pc;
        end
    end

    // Handshake outputs decode directly from the state register.
    assign imem_req    = (state == REQ);
    assign instr_valid = (state == HOLD);
    assign busy        = (state != IDLE);

    assign pc_plus1  = pc + ADDR_W'(1);
    assign imem_addr = pc;

`ifdef PC_TRACE_EN
    always @(posedge clk) begin
        if (!reset && accept)
            $display("pc_trace: pc %h -> %h instr %h", pc, next_pc, instr);
    end
`endif

endmodule
